// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter.
//   tx_state_e   - transmitter FSM states
//   FE_PARITY    - falling-edge index after which the parity bit is driven
//   FE_STOP      - falling-edge index after which the line is released (stop)
//   FE_ACK       - falling-edge index at which the device ACK is sampled
//   RETRY_LIMIT  - retries allowed when PS2_TX_RETRY_EN is defined
//   odd_parity() - odd parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ_DATA,
    XFER,
    ACKWAIT,
    FAIL
  } tx_state_e;

  localparam logic [3:0] FE_PARITY   = 4'd9;
  localparam logic [3:0] FE_STOP     = 4'd10;
  localparam logic [3:0] FE_ACK      = 4'd11;
  localparam logic [1:0] RETRY_LIMIT = 2'd2;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 line.
//   2-flop synchronizer, then a glitch filter that only changes its output
//   after FILTER_LEN consecutive identical synchronized samples, plus a
//   single-cycle strobe on each filtered 1->0 transition.
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low reset
//   line_i   raw pin level
//   level_o  filtered level (RESET_VAL after reset)
//   fe_o     one-cycle falling-edge strobe, aligned with level_o going 0
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8,
  parameter logic        RESET_VAL  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fe_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fe_q, fe_d;

  // cnt_q counts consecutive samples that disagree with the filtered level;
  // any agreeing sample restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    fe_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {2{RESET_VAL}};
      filt_q <= RESET_VAL;
      cnt_q  <= '0;
      fe_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fe_q   <= fe_d;
    end
  end

  assign level_o = filt_q;
  assign fe_o    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (one byte per request).
//   Request-to-send (clock inhibit), start bit, 8 data bits LSB first, odd
//   parity, stop, device ACK, with a timeout measured from clock release.
// Ports:
//   clk25       25 MHz system clock
//   rst_n       synchronous active-low reset
//   tx_data     byte to send, captured when tx_start is accepted
//   tx_start    one-cycle request, accepted only when idle
//   tx_busy     high from the cycle after acceptance until back to idle
//   tx_done     one-cycle pulse: byte ACKed by device
//   tx_error    one-cycle pulse: NACK or timeout
//   rx_inhibit  high while busy; receiver ignores the lines
//   ps2_clk_in  raw PS/2 clock pin
//   ps2_dat_in  raw PS/2 data pin
//   ps2_clk_oe  1 = pull clock line low
//   ps2_dat_oe  1 = pull data line low
// Build option: PS2_TX_RETRY_EN - retry a failed byte up to RETRY_LIMIT times
//   before reporting tx_error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_e      state_q, state_d;
  logic [7:0]     data_q, data_d;
  logic           par_q, par_d;
  logic [3:0]     n_q, n_d;
  logic [ICW-1:0] inh_q, inh_d;
  logic [TCW-1:0] tmo_q, tmo_d, tmo_inc;
  logic           done_q, done_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]     retry_q, retry_d;
`endif

  logic clk_f, clk_fe, dat_f, dat_fe_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_clk_filt (
    .clk_i  (clk25),
    .rst_ni (rst_n),
    .line_i (ps2_clk_in),
    .level_o(clk_f),
    .fe_o   (clk_fe)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_dat_filt (
    .clk_i  (clk25),
    .rst_ni (rst_n),
    .line_i (ps2_dat_in),
    .level_o(dat_f),
    .fe_o   (dat_fe_unused)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    par_d    = par_q;
    n_d      = n_q;
    inh_d    = inh_q;
    tmo_d    = tmo_q;
    done_d   = 1'b0;
    tx_error = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d  = retry_q;
`endif
    tmo_inc = (tmo_q == TCW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        n_d   = '0;
        inh_d = '0;
        if (tx_start) begin
          data_d  = tx_data;
          par_d   = odd_parity(tx_data);
          state_d = INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      // INHIBIT plus the single REQ_DATA cycle make up the clock-low window,
      // so INHIBIT itself lasts one cycle less than INHIBIT_CYCLES.
      INHIBIT: begin
        if (inh_q >= ICW'(INHIBIT_CYCLES - 2)) begin
          state_d = REQ_DATA;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      REQ_DATA: begin
        state_d = XFER;
        n_d     = '0;
        tmo_d   = '0;
      end
      XFER: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TCW'(TIMEOUT_CYCLES)) begin
          state_d = FAIL;
        end else if (clk_fe) begin
          n_d = n_q + 4'd1;
          if (n_q + 4'd1 == FE_ACK) begin
            state_d = dat_f ? FAIL : ACKWAIT;
          end
        end
      end
      ACKWAIT: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TCW'(TIMEOUT_CYCLES)) begin
          state_d = FAIL;
        end else if (clk_f && dat_f) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      FAIL: begin
`ifdef PS2_TX_RETRY_EN
        if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + 2'd1;
          inh_d   = '0;
          state_d = INHIBIT;
        end else begin
          tx_error = 1'b1;
          state_d  = IDLE;
        end
`else
        tx_error = 1'b1;
        state_d  = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      n_q     <= '0;
      inh_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      n_q     <= n_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge clk25) begin
    if (!rst_n) retry_q <= '0;
    else        retry_q <= retry_d;
  end
`endif

  // Line drives decode straight from registered state so a reset releases
  // both lines on the same edge.
  always_comb begin
    ps2_dat_oe = 1'b0;
    unique case (state_q)
      REQ_DATA: ps2_dat_oe = 1'b1;
      XFER: begin
        if (n_q == 4'd0)           ps2_dat_oe = 1'b1;
        else if (n_q <= 4'd8)      ps2_dat_oe = ~data_q[3'(n_q - 4'd1)];
        else if (n_q == FE_PARITY) ps2_dat_oe = ~par_q;
        else                       ps2_dat_oe = 1'b0;
      end
      default: ps2_dat_oe = 1'b0;
    endcase
  end

  assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == REQ_DATA);
  assign tx_busy    = (state_q != IDLE);
  assign rx_inhibit = (state_q != IDLE);
  assign tx_done    = done_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH  = 2500;
  localparam int TMO  = 6000;
  localparam int HALF = 30;
  localparam int QTR  = 8;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk25 = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error, rx_inhibit;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low, dev_dat_low;

  int checks = 0;
  int failures = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (8)
  ) dut (
    .clk25     (clk25),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .rx_inhibit(rx_inhibit),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #20 clk25 = ~clk25;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame as seen by the device: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    int unsigned ones;
    ones = 0;
    f[0] = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      ones += 32'(d[i]);
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Bus monitor
  int   cyc = 0, low_run = 0, last_low = 0, phases = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, rel_cyc = 0, err_cyc = 0;
  logic prev_oe = 1'b0;
  logic [1:0] oe_at_err = 2'b00;

  always @(negedge clk25) begin
    cyc++;
    if (ps2_clk_oe) begin
      if (!prev_oe) begin
        phases++;
        low_run = 0;
      end
      low_run++;
    end else if (prev_oe) begin
      last_low = low_run;
      rel_cyc  = cyc;
    end
    prev_oe = ps2_clk_oe;
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc   = cyc;
      oe_at_err = {ps2_clk_oe, ps2_dat_oe};
    end
    if (tx_done && tx_error) both_cnt++;
  end

  initial begin
    repeat (95000) @(posedge clk25);
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk25);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk25);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (tx_busy && k < bound) begin
      @(negedge clk25);
      k++;
    end
    check_eq({tag, "_idle"}, tx_busy, 0);
    repeat (3) @(negedge clk25);
  endtask

  // Device model: clocks out nfe falling edges, samples on rising edges,
  // optionally ACKs at edge 11, optionally fires a stray tx_start at edge inj_k.
  task automatic dev_frame(input bit ack, input int nfe, input int inj_k, output logic [10:0] obs);
    int k;
    obs = '0;
    k = 0;
    while (!ps2_clk_oe && k < 20) begin
      @(negedge clk25);
      k++;
    end
    k = 0;
    while (ps2_clk_oe && k < INH + 100) begin
      @(negedge clk25);
      k++;
    end
    check_eq("clk_release", ps2_clk_oe, 0);
    if (ps2_clk_oe) return;
    obs[0] = ps2_dat_in;
    check_eq("busy_xfer", {tx_busy, rx_inhibit}, 2'b11);
    repeat (HALF) @(negedge clk25);
    for (int i = 1; i <= 11 && i <= nfe; i++) begin
      if (i == 11 && ack) begin
        dev_dat_low = 1'b1;
        repeat (QTR) @(negedge clk25);
      end
      dev_clk_low = 1'b1;
      if (i == inj_k) begin
        repeat (4) @(negedge clk25);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk25);
        tx_start = 1'b0;
        repeat (HALF - 5) @(negedge clk25);
      end else begin
        repeat (HALF) @(negedge clk25);
      end
      dev_clk_low = 1'b0;
      if (i <= 10) obs[i] = ps2_dat_in;
      repeat (HALF) @(negedge clk25);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic xfer_ok(input string tag, input logic [7:0] d, input int inj_k);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int p0 = phases;
    logic [10:0] obs;
    start_tx(d);
    dev_frame(1'b1, 11, inj_k, obs);
    wait_idle(tag, 400);
    repeat (50) @(negedge clk25);
    check_eq({tag, "_low"}, last_low, INH);
    check_eq({tag, "_bits"}, {21'd0, obs}, {21'd0, frame_bits(d)});
    check_eq({tag, "_done"}, done_cnt - d0, 1);
    check_eq({tag, "_err"}, err_cnt - e0, 0);
    check_eq({tag, "_phases"}, phases - p0, 1);
  endtask

  initial begin
    logic [10:0] obs;
    int d0, e0, p0;
    rst_n = 1'b0;
    tx_data = '0;
    tx_start = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (4) @(posedge clk25);
    #1;
    check_eq("reset_outs", {tx_busy, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_dat_oe}, 0);
    @(negedge clk25);
    rst_n = 1'b1;
    repeat (20) @(negedge clk25);

    // Accept-to-clock-inhibit latency
    @(negedge clk25);
    tx_data  = 8'hED;
    tx_start = 1'b1;
    @(posedge clk25);
    #1;
    tx_start = 1'b0;
    check_eq("lat_clk_oe", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 3'b101);
    dev_frame(1'b1, 11, 0, obs);
    wait_idle("ed", 400);
    check_eq("ed_low", last_low, INH);
    check_eq("ed_bits", {21'd0, obs}, {21'd0, frame_bits(8'hED)});
    check_eq("ed_done", done_cnt, 1);

    xfer_ok("p00", 8'h00, 0);
    xfer_ok("pff", 8'hFF, 0);
    xfer_ok("p01", 8'h01, 0);
    for (int i = 0; i < 3; i++) xfer_ok($sformatf("rand%0d", i), 8'($urandom_range(0, 255)), 0);

    // NACK
    d0 = done_cnt; e0 = err_cnt; p0 = phases;
    start_tx(8'hA5);
    for (int r = 0; r < ATTEMPTS; r++) dev_frame(1'b0, 11, 0, obs);
    wait_idle("nack", 400);
    check_eq("nack_err", err_cnt - e0, 1);
    check_eq("nack_done", done_cnt - d0, 0);
    check_eq("nack_phases", phases - p0, ATTEMPTS);
    check_eq("nack_oe", oe_at_err, 0);
    check_eq("nack_oe_idle", {ps2_clk_oe, ps2_dat_oe}, 0);

    // Timeout: device never clocks
    d0 = done_cnt; e0 = err_cnt; p0 = phases;
    start_tx(8'h3C);
    wait_idle("tmo", ATTEMPTS * (INH + TMO + 50));
    check_eq("tmo_err", err_cnt - e0, 1);
    check_eq("tmo_done", done_cnt - d0, 0);
    check_eq("tmo_latency", err_cyc - rel_cyc, TMO);
    check_eq("tmo_phases", phases - p0, ATTEMPTS);

    // Start request while busy is dropped
    xfer_ok("busy_ign", 8'hF4, 5);

    // Reset mid-frame
    start_tx(8'hED);
    dev_frame(1'b1, 2, 0, obs);
    check_eq("pre_rst_dat", {ps2_dat_oe, tx_busy}, 2'b11);
    rst_n = 1'b0;
    @(posedge clk25);
    #1;
    check_eq("rst_mid", {ps2_clk_oe, ps2_dat_oe, tx_busy}, 0);
    @(negedge clk25);
    rst_n = 1'b1;
    repeat (20) @(negedge clk25);
    xfer_ok("post_rst", 8'hED, 0);

    check_eq("done_err_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
